// File: rtl/sgmii_phy_init_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sgmii_phy_init_ctrl: GTX SGMII PHY bring-up and fault-recovery sequencer |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sgmii_phy_init_ctrl #(
  parameter int unsigned SYNC_STAGES        = 2,
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned RESET_PULSE_CYCLES = 16,
  parameter int unsigned RESETDONE_TIMEOUT  = 50000,
  parameter int unsigned ALIGN_CYCLES       = 256,
  parameter int unsigned ELECIDLE_CYCLES    = 64
) (
  input  logic       clk_ds_i,
  input  logic       mgt_reset,
  input  logic       link_enable,
  input  logic       sgmii_pll_locked,
  input  logic       sgmii_resetdone,
  input  logic       sgmii_elecidle,
  input  logic [2:0] sgmii_rxbufstatus,
  output logic       sgmii_txreset,
  output logic       sgmii_rxreset,
  output logic       sgmii_encommaalign,
  output logic       sgmii_powerdown,
  output logic       phy_ready,
  output logic [2:0] init_state,
  output logic [7:0] retry_count,
  output logic       err_timeout
);

  localparam logic [2:0] c_idle      = 3'd0;
  localparam logic [2:0] c_wait_lock = 3'd1;
  localparam logic [2:0] c_reset     = 3'd2;
  localparam logic [2:0] c_wait_done = 3'd3;
  localparam logic [2:0] c_align     = 3'd4;
  localparam logic [2:0] c_run       = 3'd5;

  localparam logic [15:0] c_lock_last  = 16'(LOCK_STABLE_CYCLES - 1);
  localparam logic [15:0] c_pulse_last = 16'(RESET_PULSE_CYCLES - 1);
  localparam logic [15:0] c_tmo_last   = 16'(RESETDONE_TIMEOUT - 1);
  localparam logic [15:0] c_align_last = 16'(ALIGN_CYCLES - 1);
  localparam logic [15:0] c_eidle_last = 16'(ELECIDLE_CYCLES - 1);

  logic [3:0] async_in;
  logic [3:0] sync_s;
  logic       lock_s, done_s, eidle_s, buferr_s;
  logic       unused_rxbuf_bits;

  assign async_in          = {sgmii_rxbufstatus[2], sgmii_elecidle, sgmii_resetdone, sgmii_pll_locked};
  assign unused_rxbuf_bits = ^sgmii_rxbufstatus[1:0];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] chain_q;
      logic [SYNC_STAGES-1:0] chain_d;

      always_comb chain_d = {chain_q[SYNC_STAGES-2:0], async_in[gi]};

      always_ff @(posedge clk_ds_i or posedge mgt_reset) begin
        if (mgt_reset) chain_q <= '0;
        else           chain_q <= chain_d;
      end

      assign sync_s[gi] = chain_q[SYNC_STAGES-1];
    end
  endgenerate

  assign lock_s   = sync_s[0];
  assign done_s   = sync_s[1];
  assign eidle_s  = sync_s[2];
  assign buferr_s = sync_s[3];

  logic [2:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  retry_q, retry_d;
  logic        err_q, err_d;
  logic        retry_inc;

  logic        txreset_q, txreset_d;
  logic        rxreset_q, rxreset_d;
  logic        align_q, align_d;
  logic        pdown_q, pdown_d;
  logic        ready_q, ready_d;
  logic [2:0]  init_state_q, init_state_d;

  always_ff @(posedge clk_ds_i or posedge mgt_reset) begin
    if (mgt_reset) begin
      state_q      <= c_idle;
      cnt_q        <= '0;
      retry_q      <= '0;
      err_q        <= 1'b0;
      txreset_q    <= 1'b1;
      rxreset_q    <= 1'b1;
      align_q      <= 1'b0;
      pdown_q      <= 1'b1;
      ready_q      <= 1'b0;
      init_state_q <= c_idle;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      err_q        <= err_d;
      txreset_q    <= txreset_d;
      rxreset_q    <= rxreset_d;
      align_q      <= align_d;
      pdown_q      <= pdown_d;
      ready_q      <= ready_d;
      init_state_q <= init_state_d;
    end
  end

  // Faults are checked ahead of the per-state progress so one transition wins.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    retry_inc = 1'b0;

    if (!link_enable) begin
      state_d = c_idle;
    end else if (!lock_s && (state_q == c_reset || state_q == c_wait_done ||
                             state_q == c_align || state_q == c_run)) begin
      state_d   = c_wait_lock;
      retry_inc = 1'b1;
    end else if (buferr_s && (state_q == c_align || state_q == c_run)) begin
      state_d   = c_reset;
      retry_inc = 1'b1;
    end else begin
      case (state_q)
        c_idle: state_d = c_wait_lock;
        c_wait_lock: begin
          if (!lock_s)                  cnt_d   = '0;
          else if (cnt_q == c_lock_last) state_d = c_reset;
          else                          cnt_d   = cnt_q + 16'd1;
        end
        c_reset: begin
          if (cnt_q == c_pulse_last) state_d = c_wait_done;
          else                       cnt_d   = cnt_q + 16'd1;
        end
        c_wait_done: begin
          if (done_s) begin
            state_d = c_align;
          end else if (cnt_q == c_tmo_last) begin
            state_d   = c_reset;
            retry_inc = 1'b1;
            err_d     = 1'b1;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        c_align: begin
          if (eidle_s)                    cnt_d   = '0;
          else if (cnt_q == c_align_last) state_d = c_run;
          else                            cnt_d   = cnt_q + 16'd1;
        end
        c_run: begin
          if (!eidle_s)                   cnt_d   = '0;
          else if (cnt_q == c_eidle_last) state_d = c_align;
          else                            cnt_d   = cnt_q + 16'd1;
        end
        default: state_d = c_idle;
      endcase
    end

    if (state_d != state_q) cnt_d = '0;
    retry_d = (retry_inc && retry_q != 8'hFF) ? retry_q + 8'd1 : retry_q;
  end

  always_comb begin
    txreset_d    = 1'b0;
    rxreset_d    = 1'b0;
    align_d      = 1'b0;
    pdown_d      = 1'b0;
    ready_d      = 1'b0;
    init_state_d = state_q;
    case (state_q)
      c_wait_lock, c_reset: begin
        txreset_d = 1'b1;
        rxreset_d = 1'b1;
      end
      c_wait_done: ;
      c_align: align_d = 1'b1;
      c_run: begin
        align_d = 1'b1;
        ready_d = 1'b1;
      end
      default: begin
        txreset_d = 1'b1;
        rxreset_d = 1'b1;
        pdown_d   = 1'b1;
      end
    endcase
  end

  assign sgmii_txreset      = txreset_q;
  assign sgmii_rxreset      = rxreset_q;
  assign sgmii_encommaalign = align_q;
  assign sgmii_powerdown    = pdown_q;
  assign phy_ready          = ready_q;
  assign init_state         = init_state_q;
  assign retry_count        = retry_q;
  assign err_timeout        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_sgmii_phy_init_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sgmii_phy_init_ctrl: scoreboard bench for the SGMII init sequencer    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_sgmii_phy_init_ctrl;

  typedef logic [12:0] exp_t;  // {state, phy_ready, retry_count, err_timeout}

  logic       clk_ds_i = 1'b0;
  logic       mgt_reset = 1'b0;
  logic       link_enable = 1'b0;
  logic       sgmii_pll_locked = 1'b0;
  logic       sgmii_resetdone = 1'b0;
  logic       sgmii_elecidle = 1'b0;
  logic [2:0] sgmii_rxbufstatus = 3'b000;
  logic       sgmii_txreset, sgmii_rxreset, sgmii_encommaalign, sgmii_powerdown;
  logic       phy_ready, err_timeout;
  logic [2:0] init_state;
  logic [7:0] retry_count;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  sgmii_phy_init_ctrl #(
    .SYNC_STAGES       (2),
    .LOCK_STABLE_CYCLES(8),
    .RESET_PULSE_CYCLES(4),
    .RESETDONE_TIMEOUT (32),
    .ALIGN_CYCLES      (8),
    .ELECIDLE_CYCLES   (4)
  ) dut (
    .clk_ds_i          (clk_ds_i),
    .mgt_reset         (mgt_reset),
    .link_enable       (link_enable),
    .sgmii_pll_locked  (sgmii_pll_locked),
    .sgmii_resetdone   (sgmii_resetdone),
    .sgmii_elecidle    (sgmii_elecidle),
    .sgmii_rxbufstatus (sgmii_rxbufstatus),
    .sgmii_txreset     (sgmii_txreset),
    .sgmii_rxreset     (sgmii_rxreset),
    .sgmii_encommaalign(sgmii_encommaalign),
    .sgmii_powerdown   (sgmii_powerdown),
    .phy_ready         (phy_ready),
    .init_state        (init_state),
    .retry_count       (retry_count),
    .err_timeout       (err_timeout)
  );

  always #4 clk_ds_i = ~clk_ds_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [2:0] s, input logic rdy, input logic [7:0] rty, input logic err);
    sb.push_back({s, rdy, rty, err});
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    int n = 0;
    while (init_state !== s && n < budget) begin
      @(negedge clk_ds_i);
      n++;
    end
    chk(name, {29'd0, init_state}, {29'd0, s});
  endtask

  task automatic dwell(input logic [2:0] s, input string name, input int exp_cycles);
    int n = 0;
    while (init_state === s && n < 200) begin
      @(negedge clk_ds_i);
      n++;
    end
    chk(name, n, exp_cycles);
  endtask

  // resetdone rises five cycles after the PHY resets are released
  task automatic finish_bringup(input string name);
    int n = 0;
    while (sgmii_txreset !== 1'b0 && n < 200) begin
      @(negedge clk_ds_i);
      n++;
    end
    repeat (5) @(posedge clk_ds_i);
    #1 sgmii_resetdone = 1'b1;
    wait_state(3'd5, 200, name);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_txreset"},    sgmii_txreset,      1);
    chk({tag, "_rxreset"},    sgmii_rxreset,      1);
    chk({tag, "_align"},      sgmii_encommaalign, 0);
    chk({tag, "_powerdown"},  sgmii_powerdown,    1);
    chk({tag, "_phy_ready"},  phy_ready,          0);
    chk({tag, "_init_state"}, init_state,         0);
    chk({tag, "_retry"},      retry_count,        0);
    chk({tag, "_err"},        err_timeout,        0);
  endtask

  // Monitor: every visible state change consumes one scoreboard entry
  initial begin
    logic [2:0] prev;
    exp_t       e;
    prev = 3'd0;
    forever begin
      @(negedge clk_ds_i);
      if (init_state !== prev) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_transition: got state %0d from %0d expected none", init_state, prev);
        end else begin
          e = sb.pop_front();
          chk("transition", {19'd0, init_state, phy_ready, retry_count, err_timeout}, {19'd0, e});
        end
        prev = init_state;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int r;

    #2 mgt_reset = 1'b1;
    #1 chk_reset_values("por");
    repeat (3) @(posedge clk_ds_i);
    #1 mgt_reset = 1'b0;

    // Clean bring-up
    push(3'd1, 0, 0, 0); push(3'd2, 0, 0, 0); push(3'd3, 0, 0, 0);
    push(3'd4, 0, 0, 0); push(3'd5, 1, 0, 0);
    @(posedge clk_ds_i);
    #1 link_enable = 1'b1; sgmii_pll_locked = 1'b1;
    wait_state(3'd2, 100, "bringup_reach_reset");
    dwell(3'd2, "reset_dwell", 4);
    finish_bringup("bringup_reach_run");
    chk("run_ready",     phy_ready,          1);
    chk("run_align",     sgmii_encommaalign, 1);
    chk("run_txreset",   sgmii_txreset,      0);
    chk("run_rxreset",   sgmii_rxreset,      0);
    chk("run_powerdown", sgmii_powerdown,    0);
    chk("run_retry",     retry_count,        0);

    // Lock glitch at WAIT_LOCK count 5
    push(3'd0, 0, 0, 0);
    @(posedge clk_ds_i);
    #1 link_enable = 1'b0; sgmii_resetdone = 1'b0;
    wait_state(3'd0, 20, "disable_to_idle");
    chk("idle_powerdown", sgmii_powerdown, 1);
    push(3'd1, 0, 0, 0); push(3'd2, 0, 0, 0); push(3'd3, 0, 0, 0);
    push(3'd4, 0, 0, 0); push(3'd5, 1, 0, 0);
    @(posedge clk_ds_i);
    #1 link_enable = 1'b1;
    wait_state(3'd1, 20, "glitch_wait_lock");
    @(posedge clk_ds_i);
    @(posedge clk_ds_i);
    #1 sgmii_pll_locked = 1'b0;
    @(posedge clk_ds_i);
    #1 sgmii_pll_locked = 1'b1;
    n = 0;
    while (init_state !== 3'd2 && n < 100) begin
      @(negedge clk_ds_i);
      n++;
    end
    chk("lock_glitch_delay", n, 12);
    finish_bringup("glitch_reach_run");

    // Buffer error pulse in RUN
    push(3'd2, 0, 1, 0); push(3'd3, 0, 1, 0); push(3'd4, 0, 1, 0); push(3'd5, 1, 1, 0);
    @(posedge clk_ds_i);
    #1 sgmii_rxbufstatus = 3'b100;
    @(posedge clk_ds_i);
    #1 sgmii_rxbufstatus = 3'b000;
    n = 0;
    while (init_state !== 3'd2 && n < 50) begin
      @(negedge clk_ds_i);
      n++;
    end
    chk("buferr_delay", n, 4);
    chk("buferr_ready", phy_ready, 0);
    wait_state(3'd5, 200, "buferr_recover_run");

    // Electrical idle: 3 cycles tolerated, 4 cycles force re-alignment
    @(posedge clk_ds_i);
    #1 sgmii_elecidle = 1'b1;
    repeat (3) @(posedge clk_ds_i);
    #1 sgmii_elecidle = 1'b0;
    repeat (10) @(negedge clk_ds_i);
    chk("eidle3_state", init_state, 5);
    chk("eidle3_ready", phy_ready,  1);
    push(3'd4, 0, 1, 0); push(3'd5, 1, 1, 0);
    @(posedge clk_ds_i);
    #1 sgmii_elecidle = 1'b1;
    repeat (4) @(posedge clk_ds_i);
    #1 sgmii_elecidle = 1'b0;
    wait_state(3'd4, 50, "eidle4_to_align");
    wait_state(3'd5, 100, "eidle4_back_run");
    chk("eidle4_retry", retry_count, 1);

    // Disable coinciding with synchronised lock loss: disable wins
    push(3'd0, 0, 1, 0);
    @(posedge clk_ds_i);
    #1 sgmii_pll_locked = 1'b0;
    @(posedge clk_ds_i);
    @(posedge clk_ds_i);
    #1 link_enable = 1'b0; sgmii_resetdone = 1'b0;
    wait_state(3'd0, 20, "priority_to_idle");
    repeat (5) @(negedge clk_ds_i);
    chk("priority_retry", retry_count, 1);

    // Resetdone timeouts until retry_count saturates
    push(3'd1, 0, 1, 0); push(3'd2, 0, 1, 0); push(3'd3, 0, 1, 0);
    r = 1;
    for (int i = 0; i < 300; i++) begin
      r = (r == 255) ? 255 : r + 1;
      push(3'd2, 0, 8'(r), 1);
      push(3'd3, 0, 8'(r), 1);
    end
    @(posedge clk_ds_i);
    #1 link_enable = 1'b1; sgmii_pll_locked = 1'b1;
    wait_state(3'd3, 100, "timeout_wait_done");
    dwell(3'd3, "timeout_dwell", 32);
    n = 0;
    while (sb.size() != 0 && n < 20000) begin
      @(negedge clk_ds_i);
      n++;
    end
    chk("timeout_drain", sb.size(), 0);
    chk("retry_saturated", retry_count, 255);
    chk("err_sticky",      err_timeout, 1);
    push(3'd4, 0, 255, 1); push(3'd5, 1, 255, 1);
    sgmii_resetdone = 1'b1;
    wait_state(3'd5, 100, "timeout_recover_run");

    // Asynchronous reset mid-RUN
    push(3'd0, 0, 0, 0);
    @(posedge clk_ds_i);
    #1 mgt_reset = 1'b1;
    #1 chk_reset_values("async");
    link_enable = 1'b0;
    repeat (3) @(posedge clk_ds_i);
    #1 mgt_reset = 1'b0;
    repeat (5) @(negedge clk_ds_i);
    chk("scoreboard_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
